array_a_skew_feeder: RTL and testbench

- Sits directly downstream of the A-operand address generator and the A buffer.
- Captures each buffer read word (ARRAY_HEIGHT elements, one per array row) after a fixed read latency.
- Skews the word diagonally so row r enters the systolic array left edge r cycles after row 0.
- Drains the skew after the final word and reports completion to the controller.

---
 rtl/mm_pkg.sv | 20 ++
 rtl/array_a_skew_feeder_if.sv | 36 +++
 rtl/skew_delay_line.sv | 28 ++
 rtl/array_a_skew_feeder.sv | 116 +++++++++++
 tb/tb_array_a_skew_feeder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the A-operand feed path of the matrix array.
package mm_pkg;

   localparam int DEF_ARRAY_HEIGHT = 4;
   localparam int DEF_DATA_WIDTH   = 8;

   typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

   // Extra cycles the deepest lane lags lane 0.
   function automatic int skew_depth(input int height);
      return height - 1;
   endfunction

endpackage

// File: rtl/array_a_skew_feeder_if.sv
// Controller/buffer-side bundle of the A skew feeder.
// Optional A_SKEW_FEEDER_STATS_EN adds the word/gap counters.
interface array_a_skew_feeder_if #(
   parameter int ARRAY_HEIGHT = 4,
   parameter int DATA_WIDTH   = 8
);
   logic                               start_i;
   logic                               gen_active_i;
   logic                               gen_done_i;
   logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] rd_data_i;
   logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] a_row_o;
   logic [ARRAY_HEIGHT-1:0]            a_valid_o;
   logic                               busy_o;
   logic                               done_o;
`ifdef A_SKEW_FEEDER_STATS_EN
   logic [15:0]                        word_cnt_o;
   logic [15:0]                        gap_cnt_o;
`endif

   modport master (
      output start_i, gen_active_i, gen_done_i, rd_data_i,
`ifdef A_SKEW_FEEDER_STATS_EN
      input  word_cnt_o, gap_cnt_o,
`endif
      input  a_row_o, a_valid_o, busy_o, done_o
   );

   modport slave (
      input  start_i, gen_active_i, gen_done_i, rd_data_i,
`ifdef A_SKEW_FEEDER_STATS_EN
      output word_cnt_o, gap_cnt_o,
`endif
      output a_row_o, a_valid_o, busy_o, done_o
   );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth register shift line with synchronous clear; q lags d by DEPTH cycles.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/array_a_skew_feeder.sv
// Aligns A-buffer read words to their addresses and skews them diagonally into the array rows.
// Optional A_SKEW_FEEDER_STATS_EN adds captured-word and FEED-gap counters.
module array_a_skew_feeder
   import mm_pkg::*;
#(
   parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int RD_LATENCY   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   array_a_skew_feeder_if.slave bus
);

   localparam int SKEW  = skew_depth(ARRAY_HEIGHT);
   localparam int CNT_W = $clog2(ARRAY_HEIGHT);

   feeder_state_t         state, state_nxt;
   logic [RD_LATENCY-1:0] rd_vld_sr, rd_last_sr;
   logic                  start_acc, cap_vld, cap_last, capture;
   logic [CNT_W-1:0]      drain_cnt;

   assign start_acc = (state == IDLE) && bus.start_i;

   // Address-side qualifiers delayed to line up with rd_data_i.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_vld_sr  <= '0;
         rd_last_sr <= '0;
      end else if (start_acc) begin
         rd_vld_sr  <= '0;
         rd_last_sr <= '0;
      end else begin
         rd_vld_sr  <= (rd_vld_sr << 1) | RD_LATENCY'(bus.gen_active_i);
         rd_last_sr <= (rd_last_sr << 1) | RD_LATENCY'(bus.gen_active_i & bus.gen_done_i);
      end
   end

   assign cap_vld  = rd_vld_sr[RD_LATENCY-1];
   assign cap_last = rd_last_sr[RD_LATENCY-1];
   assign capture  = (state == FEED) && cap_vld;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start_i)            state_nxt = FEED;
         FEED:    if (cap_vld && cap_last)    state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == '0)        state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy_o = (state != IDLE);
      bus.done_o = (state == DRAIN) && (drain_cnt == '0);
   end

   // Counts down until the last word's element leaves the deepest lane.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         drain_cnt <= '0;
      else if (capture && cap_last)
         drain_cnt <= CNT_W'(SKEW);
      else if ((state == DRAIN) && (drain_cnt != '0))
         drain_cnt <= drain_cnt - CNT_W'(1);
   end

   for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_lane
      logic [DATA_WIDTH:0] lane_d, lane_q;

      // Empty slots carry forced zeros so the array never sees stale operands.
      assign lane_d = capture ? {1'b1, bus.rd_data_i[r*DATA_WIDTH +: DATA_WIDTH]} : '0;

      skew_delay_line #(
         .DEPTH (r + 1),
         .WIDTH (DATA_WIDTH + 1)
      ) u_dly (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (start_acc),
         .d       (lane_d),
         .q       (lane_q)
      );

      assign bus.a_valid_o[r]                          = lane_q[DATA_WIDTH];
      assign bus.a_row_o[r*DATA_WIDTH +: DATA_WIDTH]   = lane_q[DATA_WIDTH-1:0];
   end

`ifdef A_SKEW_FEEDER_STATS_EN
   logic [15:0] word_cnt, gap_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_cnt <= '0;
         gap_cnt  <= '0;
      end else if (start_acc) begin
         word_cnt <= '0;
         gap_cnt  <= '0;
      end else if (state == FEED) begin
         if (capture && (word_cnt != 16'hFFFF))
            word_cnt <= word_cnt + 16'd1;
         if (!capture && (gap_cnt != 16'hFFFF))
            gap_cnt <= gap_cnt + 16'd1;
      end
   end

   assign bus.word_cnt_o = word_cnt;
   assign bus.gap_cnt_o  = gap_cnt;
`endif

endmodule

// File: tb/tb_array_a_skew_feeder.sv
// Random and directed jobs into two feeders (read latency 1 and 2) against a cycle-indexed expectation table.
module tb_array_a_skew_feeder;

   localparam int H     = 4;
   localparam int DW    = 8;
   localparam int W     = H * DW;
   localparam int MAXC  = 4096;
   localparam int INF   = 1 << 30;
   localparam int NJOBS = 30;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   array_a_skew_feeder_if #(.ARRAY_HEIGHT(H), .DATA_WIDTH(DW)) bus1 ();
   array_a_skew_feeder_if #(.ARRAY_HEIGHT(H), .DATA_WIDTH(DW)) bus2 ();

   array_a_skew_feeder #(.ARRAY_HEIGHT(H), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1.slave));
   array_a_skew_feeder #(.ARRAY_HEIGHT(H), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 10;

   int lat [2];
   int start_cyc [2];
   int done_cyc [2];
   int words [2];
   int fin_wc [2];
   int fin_gc [2];
   int done_seen [2];
   bit in_feed [2];

   logic [W-1:0] exp_row [2][MAXC];
   logic [H-1:0] exp_vld [2][MAXC];
   logic [W-1:0] hist_w [MAXC];
   bit           hist_a [MAXC];

   logic [W-1:0] job_w [16];
   bit           job_a [16];
   int           job_len;
   int           job_start;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit busy_at(input int d, input int c);
      return (start_cyc[d] != INF) && (c > start_cyc[d]) && (c <= done_cyc[d]);
   endfunction

   // Reference: a word accepted at cycle c shows on lane r at c+lat+1+r; done at c_last+lat+H.
   task automatic model_cycle(input int d, input bit st, input bit act, input bit dn, input logic [W-1:0] w);
      if (st && !busy_at(d, cyc)) begin
         start_cyc[d] = cyc;
         done_cyc[d]  = INF;
         in_feed[d]   = 1'b1;
         words[d]     = 0;
      end
      if (act && in_feed[d] && (cyc > start_cyc[d])) begin
         words[d]++;
         for (int r = 0; r < H; r++) begin
            int t = cyc + lat[d] + 1 + r;
            if (t < MAXC) begin
               exp_vld[d][t][r]         = 1'b1;
               exp_row[d][t][r*DW +: DW] = w[r*DW +: DW];
            end
         end
         if (dn) begin
            in_feed[d]  = 1'b0;
            done_cyc[d] = cyc + lat[d] + H;
            fin_wc[d]   = words[d];
            fin_gc[d]   = cyc + lat[d] - start_cyc[d] - words[d];
         end
      end
   endtask

   task automatic chk_dut(input int d, input logic [W-1:0] row, input logic [H-1:0] v,
                          input logic b, input logic dn);
      chk($sformatf("a_row_o[lat%0d]", lat[d]),   64'(row), 64'(exp_row[d][cyc]));
      chk($sformatf("a_valid_o[lat%0d]", lat[d]), 64'(v),   64'(exp_vld[d][cyc]));
      chk($sformatf("busy_o[lat%0d]", lat[d]),    64'(b),   64'(busy_at(d, cyc)));
      chk($sformatf("done_o[lat%0d]", lat[d]),    64'(dn),  64'(cyc == done_cyc[d]));
      if (dn) done_seen[d] = cyc;
   endtask

`ifdef A_SKEW_FEEDER_STATS_EN
   task automatic chk_stats(input int d, input logic [15:0] wc, input logic [15:0] gc);
      if (start_cyc[d] != INF && cyc == start_cyc[d] + 1) begin
         chk($sformatf("word_cnt_clr[lat%0d]", lat[d]), 64'(wc), 64'd0);
         chk($sformatf("gap_cnt_clr[lat%0d]", lat[d]),  64'(gc), 64'd0);
      end else if (start_cyc[d] == INF) begin
         chk($sformatf("word_cnt_rst[lat%0d]", lat[d]), 64'(wc), 64'd0);
         chk($sformatf("gap_cnt_rst[lat%0d]", lat[d]),  64'(gc), 64'd0);
      end else if (done_cyc[d] != INF && cyc >= done_cyc[d]) begin
         chk($sformatf("word_cnt[lat%0d]", lat[d]), 64'(wc), 64'(fin_wc[d]));
         chk($sformatf("gap_cnt[lat%0d]", lat[d]),  64'(gc), 64'(fin_gc[d]));
      end
   endtask
`endif

   task automatic step(input bit st, input bit act, input bit dn, input logic [W-1:0] w);
      @(posedge clk);
      #1;
      cyc++;
      reset_n           = 1'b1;
      hist_w[cyc]       = w;
      hist_a[cyc]       = act;
      bus1.start_i      = st;
      bus1.gen_active_i = act;
      bus1.gen_done_i   = dn;
      bus1.rd_data_i    = hist_a[cyc-1] ? hist_w[cyc-1] : W'($urandom());
      bus2.start_i      = st;
      bus2.gen_active_i = act;
      bus2.gen_done_i   = dn;
      bus2.rd_data_i    = hist_a[cyc-2] ? hist_w[cyc-2] : W'($urandom());
      for (int d = 0; d < 2; d++) model_cycle(d, st, act, dn, w);
      @(negedge clk);
      chk_dut(0, bus1.a_row_o, bus1.a_valid_o, bus1.busy_o, bus1.done_o);
      chk_dut(1, bus2.a_row_o, bus2.a_valid_o, bus2.busy_o, bus2.done_o);
`ifdef A_SKEW_FEEDER_STATS_EN
      chk_stats(0, bus1.word_cnt_o, bus1.gap_cnt_o);
      chk_stats(1, bus2.word_cnt_o, bus2.gap_cnt_o);
`endif
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         start_cyc[d] = INF;
         done_cyc[d]  = INF;
         in_feed[d]   = 1'b0;
         words[d]     = 0;
         fin_wc[d]    = 0;
         fin_gc[d]    = 0;
         for (int t = cyc + 1; t < MAXC; t++) begin
            exp_row[d][t] = '0;
            exp_vld[d][t] = '0;
         end
      end
   endtask

   // Asserted between edges; released by the next step.
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      chk("reset_a_row_o[lat1]",   64'(bus1.a_row_o),   64'd0);
      chk("reset_a_valid_o[lat1]", 64'(bus1.a_valid_o), 64'd0);
      chk("reset_busy_o[lat1]",    64'(bus1.busy_o),    64'd0);
      chk("reset_done_o[lat1]",    64'(bus1.done_o),    64'd0);
      chk("reset_a_row_o[lat2]",   64'(bus2.a_row_o),   64'd0);
      chk("reset_a_valid_o[lat2]", 64'(bus2.a_valid_o), 64'd0);
      chk("reset_busy_o[lat2]",    64'(bus2.busy_o),    64'd0);
      chk("reset_done_o[lat2]",    64'(bus2.done_o),    64'd0);
      model_clear();
   endtask

   task automatic wait_idle(input bit stress);
      for (int k = 0; k < 40; k++) begin
         bit both, st;
         if (!busy_at(0, cyc + 1) && !busy_at(1, cyc + 1)) break;
         both = busy_at(0, cyc + 1) && busy_at(1, cyc + 1);
         st   = stress && both && ((cyc + 1 == done_cyc[0]) || ($urandom_range(0, 2) == 0));
         step(st, 1'b0, 1'b0, '0);
      end
      step(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic run_job(input bit stress);
      step(1'b1, 1'b0, 1'b0, '0);
      job_start = cyc;
      for (int i = 0; i < job_len; i++) begin
         bit st, dn;
         st = stress && ($urandom_range(0, 3) == 0);
         dn = (i == job_len - 1) || (!job_a[i] && stress && ($urandom_range(0, 2) == 0));
         step(st, job_a[i], dn, job_w[i]);
      end
      wait_idle(stress);
   endtask

   task automatic set_basic();
      job_len  = 3;
      job_w[0] = 32'h04030201;
      job_w[1] = 32'h08070605;
      job_w[2] = 32'h0C0B0A09;
      for (int i = 0; i < 3; i++) job_a[i] = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      lat[0] = 1;
      lat[1] = 2;
      for (int t = 0; t < MAXC; t++) begin
         hist_w[t] = '0;
         hist_a[t] = 1'b0;
         for (int d = 0; d < 2; d++) begin
            exp_row[d][t] = '0;
            exp_vld[d][t] = '0;
         end
      end
      model_clear();
      done_seen[0] = -1;
      done_seen[1] = -1;
      bus1.start_i = 1'b0; bus1.gen_active_i = 1'b0; bus1.gen_done_i = 1'b0; bus1.rd_data_i = '0;
      bus2.start_i = 1'b0; bus2.gen_active_i = 1'b0; bus2.gen_done_i = 1'b0; bus2.rd_data_i = '0;

      #12;
      chk("rst_busy_o",    64'(bus1.busy_o | bus2.busy_o),       64'd0);
      chk("rst_a_valid_o", 64'({bus1.a_valid_o, bus2.a_valid_o}), 64'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);

      // Basic three-word job.
      set_basic();
      run_job(1'b0);
      chk("basic_done_lat1", 64'(done_seen[0] - job_start), 64'd8);
      chk("basic_done_lat2", 64'(done_seen[1] - job_start), 64'd9);

      // Bubble in the middle.
      job_len = 3;
      job_a[0] = 1'b1; job_a[1] = 1'b0; job_a[2] = 1'b1;
      job_w[0] = 32'hA3A2A1A0; job_w[1] = 32'hDEADBEEF; job_w[2] = 32'hB3B2B1B0;
      run_job(1'b0);

      // Single-word job.
      job_len = 1;
      job_a[0] = 1'b1;
      job_w[0] = 32'h5A5A5A5A;
      run_job(1'b0);
      chk("single_done_lat2", 64'(done_seen[1] - job_start), 64'd7);

      // Extra starts during FEED and DRAIN, stray gen_done in gaps.
      job_len = 5;
      for (int i = 0; i < 5; i++) begin
         job_a[i] = (i != 1) && (i != 3);
         job_w[i] = W'($urandom());
      end
      run_job(1'b1);

      // Abort mid-FEED, then a fresh basic job.
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 32'h11111111);
      step(1'b0, 1'b1, 1'b0, 32'h22222222);
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, '0);
      set_basic();
      run_job(1'b0);
      chk("post_reset_done_lat1", 64'(done_seen[0] - job_start), 64'd8);

      for (int j = 0; j < NJOBS; j++) begin
         job_len = $urandom_range(1, 8);
         for (int i = 0; i < job_len; i++) begin
            job_a[i] = ($urandom_range(0, 9) < 7);
            job_w[i] = W'($urandom());
         end
         job_a[job_len-1] = 1'b1;
         run_job(j[0]);
         for (int i = $urandom_range(0, 2); i > 0; i--) step(1'b0, 1'b0, 1'b0, '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
